// File: rtl/spi_frame_sequencer.sv
// SPI mode-0 frame sequencer: one header byte {underrun, seq} followed by
// PAYLOAD_BYTES bytes fetched over a valid/ready handshake, then an SS-high gap.
module spi_frame_sequencer #(
  parameter int unsigned PAYLOAD_BYTES = 64,
  parameter int unsigned SCK_DIV       = 2,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       FRAME_AVAIL,
  input  logic [7:0] BYTE_DATA,
  input  logic       BYTE_VALID,
  output logic       BYTE_READY,
  output logic       MCU_SCK,
  output logic       MCU_SS,
  output logic       MCU_MOSI,
  output logic       FRAME_DONE,
  output logic       UNDERRUN
);

  localparam int unsigned DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned BYTE_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'((SCK_DIV > 1) ? SCK_DIV - 2 : 0);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PAYLOAD_BYTES);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [6:0]        shreg;
  logic [6:0]        seq;
  logic              fetch_c;

  // High when the coming edge is the falling SCK edge that ends bit 0 of a
  // byte followed by another payload byte; registered into BYTE_READY so the
  // ready pulse sits in exactly the cycle before the load edge.
  assign fetch_c = (state == SHIFT) && (bit_cnt == 3'd7) && (byte_cnt != BYTE_LAST) &&
                   ((SCK_DIV == 1) ? !MCU_SCK : (MCU_SCK && (div_cnt == DIV_PRE)));

  always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      MCU_SS     <= 1'b1;
      MCU_SCK    <= 1'b0;
      MCU_MOSI   <= 1'b0;
      BYTE_READY <= 1'b0;
      FRAME_DONE <= 1'b0;
      UNDERRUN   <= 1'b0;
      seq        <= 7'd0;
      div_cnt    <= '0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      shreg      <= 7'd0;
    end else begin
      BYTE_READY <= fetch_c;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE && FRAME_AVAIL) begin
            state    <= SHIFT;
            MCU_SS   <= 1'b0;
            MCU_SCK  <= 1'b0;
            MCU_MOSI <= UNDERRUN;
            shreg    <= seq;
            UNDERRUN <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
          end
        end

        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!MCU_SCK) begin
              MCU_SCK <= 1'b1;
            end else begin
              MCU_SCK <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt  <= bit_cnt + 3'd1;
                MCU_MOSI <= shreg[6];
                shreg    <= {shreg[5:0], 1'b0};
              end else if (byte_cnt == BYTE_LAST) begin
                state      <= GAP;
                MCU_SS     <= 1'b1;
                MCU_MOSI   <= 1'b0;
                FRAME_DONE <= 1'b1;
                seq        <= seq + 7'd1;
                gap_cnt    <= '0;
              end else begin
                // Missing byte is replaced by 0x00 so the frame length never changes.
                bit_cnt  <= 3'd0;
                byte_cnt <= byte_cnt + BYTE_W'(1);
                MCU_MOSI <= BYTE_VALID & BYTE_DATA[7];
                shreg    <= BYTE_VALID ? BYTE_DATA[6:0] : 7'd0;
                if (!BYTE_VALID) begin
                  UNDERRUN <= 1'b1;
                end
              end
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_sck_idle_when_deselected: assert property (
    @(posedge MCU_CLK_25_000) disable iff (RESET) MCU_SS |-> !MCU_SCK);

  a_done_only_deselected: assert property (
    @(posedge MCU_CLK_25_000) disable iff (RESET) FRAME_DONE |-> MCU_SS);

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer with 4-byte payload, SCK_DIV=2, GAP_CYCLES=4.
module tb_spi_frame_sequencer;

  localparam int unsigned P   = 4;
  localparam int unsigned DIV = 2;
  localparam int unsigned GAP = 4;
  localparam int FRAME_CLKS = (1 + P) * 8 * 2 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       frame_avail = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready, mcu_sck, mcu_ss, mcu_mosi, frame_done, underrun;

  int passed = 0;
  int total  = 0;

  spi_frame_sequencer #(.PAYLOAD_BYTES(P), .SCK_DIV(DIV), .GAP_CYCLES(GAP)) dut (
    .MCU_CLK_25_000(clk),
    .RESET(rst),
    .ENABLE(enable),
    .FRAME_AVAIL(frame_avail),
    .BYTE_DATA(byte_data),
    .BYTE_VALID(byte_valid),
    .BYTE_READY(byte_ready),
    .MCU_SCK(mcu_sck),
    .MCU_SS(mcu_ss),
    .MCU_MOSI(mcu_mosi),
    .FRAME_DONE(frame_done),
    .UNDERRUN(underrun)
  );

  always #5 clk = ~clk;

  // Upstream source: byte chosen by the ready pulse index within the frame.
  logic [7:0] pat [4];
  logic [1:0] ready_idx = 2'd0;
  logic       drop_active = 1'b0;
  initial begin
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h01;
  end
  assign byte_data  = pat[ready_idx];
  assign byte_valid = !(drop_active && ready_idx == 2'd1);
  always @(posedge clk) begin
    if (mcu_ss) ready_idx <= 2'd0;
    else if (byte_ready) ready_idx <= ready_idx + 2'd1;
  end

  // Passive SPI observer, sampling 1 time unit after each rising edge.
  logic [7:0] cur_bytes[$];
  logic [7:0] last_bytes[$];
  logic [7:0] headers[$];
  int         gaps[$];
  logic [7:0] byte_sh = 8'h00;
  int bit_n = 0, ss_low_cnt = 0, ss_high_cnt = 0, last_ss_low = 0;
  int ready_frame = 0, last_ready = 0, done_cnt = 0, fall_cnt = 0, cyc = 0;
  int drop_cyc = -1, ur_rise_cyc = -1, sck_viol = 0;
  bit seen_rise = 1'b0;
  logic prev_ss = 1'b1, prev_sck = 1'b0, prev_ur = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      cur_bytes.delete();
      bit_n = 0;
      seen_rise = 1'b0;
    end else begin
      if (!mcu_ss && prev_ss) begin
        fall_cnt++;
        if (seen_rise) gaps.push_back(ss_high_cnt);
        cur_bytes.delete();
        bit_n = 0;
        ss_low_cnt = 0;
        ready_frame = 0;
      end
      if (mcu_ss && !prev_ss) begin
        last_bytes = cur_bytes;
        last_ss_low = ss_low_cnt;
        last_ready = ready_frame;
        seen_rise = 1'b1;
        ss_high_cnt = 0;
      end
      if (!mcu_ss) ss_low_cnt++; else ss_high_cnt++;
      if (mcu_ss && mcu_sck) sck_viol++;
      if (mcu_sck && !prev_sck) begin
        byte_sh = {byte_sh[6:0], mcu_mosi};
        bit_n++;
        if (bit_n == 8) begin
          cur_bytes.push_back(byte_sh);
          if (cur_bytes.size() == 1) headers.push_back(byte_sh);
          bit_n = 0;
        end
      end
      if (byte_ready) ready_frame++;
      if (byte_ready && !byte_valid) drop_cyc = cyc;
      if (underrun && !prev_ur) ur_rise_cyc = cyc;
      if (frame_done) done_cnt++;
    end
    prev_ss = mcu_ss;
    prev_sck = mcu_sck;
    prev_ur = underrun;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 200; i++) begin
      if (done_cnt > base) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    frame_avail = 1'b0;
    drop_active = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enable = 1'($urandom_range(1));
      frame_avail = 1'($urandom_range(1));
      drop_active = 1'($urandom_range(1));
      tick();
      outs = {mcu_ss, mcu_sck, mcu_mosi, byte_ready, frame_done, underrun};
      total++; if (outs !== 6'b100000) $display("FAIL reset_hold[%0d]: got %b want 100000", i, outs); else passed++;
    end
    enable = 1'b0; frame_avail = 1'b0; drop_active = 1'b0;
    rst = 1'b0;
    tick(); tick();
    outs = {mcu_ss, mcu_sck, mcu_mosi, byte_ready, frame_done, underrun};
    total++; if (outs !== 6'b100000) $display("FAIL reset_release: got %b want 100000", outs); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] exp [5];
    int  base_done;
    bit  ok;
    exp[0] = 8'h00; exp[1] = 8'hA5; exp[2] = 8'h3C; exp[3] = 8'hFF; exp[4] = 8'h01;
    base_done = done_cnt;
    enable = 1'b1; frame_avail = 1'b1;
    tick();
    total++; if (mcu_ss !== 1'b0) $display("FAIL start_latency: ss got %b want 0", mcu_ss); else passed++;
    frame_avail = 1'b0;
    wait_done(base_done, ok);
    total++; if (!ok) $display("FAIL basic_timeout: done got 0 want 1"); else passed++;
    repeat (10) tick();
    total++; if (last_bytes.size() != 5) $display("FAIL basic_len: got %0d want 5", last_bytes.size()); else passed++;
    for (int i = 0; i < 5 && i < last_bytes.size(); i++) begin
      total++; if (last_bytes[i] !== exp[i]) $display("FAIL basic_byte[%0d]: got %h want %h", i, last_bytes[i], exp[i]); else passed++;
    end
    total++; if (last_ss_low != FRAME_CLKS) $display("FAIL basic_ss_low: got %0d want %0d", last_ss_low, FRAME_CLKS); else passed++;
    total++; if (last_ready != 4) $display("FAIL basic_ready_pulses: got %0d want 4", last_ready); else passed++;
    total++; if (done_cnt != base_done + 1) $display("FAIL basic_done: got %0d want %0d", done_cnt - base_done, 1); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL basic_underrun: got %b want 0", underrun); else passed++;
    frame_avail = 1'b1;
    tick();
    frame_avail = 1'b0;
    wait_done(base_done + 1, ok);
    total++; if (!ok) $display("FAIL basic2_timeout: done got 0 want 1"); else passed++;
    total++; if (last_bytes.size() == 0 || last_bytes[0] !== 8'h01) $display("FAIL basic_next_header: got %h want 01", (last_bytes.size() == 0) ? 8'hxx : last_bytes[0]); else passed++;
    total++; if (sck_viol != 0) $display("FAIL sck_while_ss_high: got %0d want 0", sck_viol); else passed++;
  endtask

  task automatic test_underrun();
    logic [7:0] exp [5];
    int  base_done;
    bit  ok;
    exp[0] = 8'h00; exp[1] = 8'hA5; exp[2] = 8'h00; exp[3] = 8'hFF; exp[4] = 8'h01;
    do_reset();
    enable = 1'b1;
    drop_active = 1'b1;
    base_done = done_cnt;
    frame_avail = 1'b1;
    tick();
    frame_avail = 1'b0;
    wait_done(base_done, ok);
    total++; if (!ok) $display("FAIL underrun_timeout: done got 0 want 1"); else passed++;
    for (int i = 0; i < 5 && i < last_bytes.size(); i++) begin
      total++; if (last_bytes[i] !== exp[i]) $display("FAIL underrun_byte[%0d]: got %h want %h", i, last_bytes[i], exp[i]); else passed++;
    end
    total++; if (underrun !== 1'b1) $display("FAIL underrun_flag: got %b want 1", underrun); else passed++;
    total++; if (ur_rise_cyc != drop_cyc + 1) $display("FAIL underrun_rise_edge: got cycle %0d want %0d", ur_rise_cyc, drop_cyc + 1); else passed++;
    drop_active = 1'b0;
    repeat (6) tick();
    frame_avail = 1'b1;
    tick();
    frame_avail = 1'b0;
    total++; if (mcu_ss !== 1'b0 || underrun !== 1'b0) $display("FAIL underrun_clear: ss/ur got %b%b want 00", mcu_ss, underrun); else passed++;
    wait_done(base_done + 1, ok);
    total++; if (!ok) $display("FAIL underrun2_timeout: done got 0 want 1"); else passed++;
    total++; if (last_bytes.size() == 0 || last_bytes[0] !== 8'h81) $display("FAIL underrun_header: got %h want 81", (last_bytes.size() == 0) ? 8'hxx : last_bytes[0]); else passed++;
    total++; if (last_bytes.size() < 3 || last_bytes[2] !== 8'h3C) $display("FAIL underrun_recovered_byte: got %h want 3c", (last_bytes.size() < 3) ? 8'hxx : last_bytes[2]); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL underrun_after: got %b want 0", underrun); else passed++;
  endtask

  task automatic test_back_to_back();
    int  base_fall, base_done;
    bit  ok;
    do_reset();
    headers.delete();
    gaps.delete();
    base_fall = fall_cnt;
    base_done = done_cnt;
    enable = 1'b1;
    frame_avail = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 129 * (FRAME_CLKS + GAP + 1) + 100; i++) begin
      if (fall_cnt >= base_fall + 129) begin ok = 1'b1; break; end
      tick();
    end
    frame_avail = 1'b0;
    total++; if (!ok) $display("FAIL b2b_timeout: falls got %0d want 129", fall_cnt - base_fall); else passed++;
    wait_done(base_done + 128, ok);
    repeat (20) tick();
    total++; if (done_cnt != base_done + 129) $display("FAIL b2b_done_count: got %0d want 129", done_cnt - base_done); else passed++;
    total++; if (headers.size() != 129) $display("FAIL b2b_header_count: got %0d want 129", headers.size()); else passed++;
    for (int i = 0; i < 129 && i < headers.size(); i++) begin
      total++; if (headers[i] !== 8'(i % 128)) $display("FAIL b2b_header[%0d]: got %h want %h", i, headers[i], 8'(i % 128)); else passed++;
    end
    total++; if (gaps.size() != 128) $display("FAIL b2b_gap_count: got %0d want 128", gaps.size()); else passed++;
    for (int i = 0; i < gaps.size(); i++) begin
      total++; if (gaps[i] != GAP + 1) $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, gaps[i], GAP + 1); else passed++;
    end
  endtask

  task automatic test_enable_drop();
    int  base_fall, base_done;
    bit  ok;
    base_fall = fall_cnt;
    base_done = done_cnt;
    enable = 1'b1;
    frame_avail = 1'b1;
    tick();
    total++; if (mcu_ss !== 1'b0) $display("FAIL endrop_start: ss got %b want 0", mcu_ss); else passed++;
    repeat (50) tick();
    enable = 1'b0;
    wait_done(base_done, ok);
    total++; if (!ok) $display("FAIL endrop_timeout: done got 0 want 1"); else passed++;
    tick();
    total++; if (last_ss_low != FRAME_CLKS) $display("FAIL endrop_ss_low: got %0d want %0d", last_ss_low, FRAME_CLKS); else passed++;
    total++; if (last_bytes.size() != 5) $display("FAIL endrop_len: got %0d want 5", last_bytes.size()); else passed++;
    repeat (50) tick();
    total++; if (fall_cnt != base_fall + 1 || mcu_ss !== 1'b1) $display("FAIL endrop_no_restart: falls got %0d want 1", fall_cnt - base_fall); else passed++;
    enable = 1'b1;
    tick();
    total++; if (mcu_ss !== 1'b0) $display("FAIL endrop_resume: ss got %b want 0", mcu_ss); else passed++;
    frame_avail = 1'b0;
    wait_done(base_done + 1, ok);
    total++; if (!ok) $display("FAIL endrop2_timeout: done got 0 want 1"); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int  base_done;
    bit  ok;
    repeat (10) tick();
    base_done = done_cnt;
    enable = 1'b1;
    frame_avail = 1'b1;
    tick();
    frame_avail = 1'b0;
    repeat (45) tick();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mcu_sck) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (!ok || mcu_ss !== 1'b0) $display("FAIL rstmid_in_frame: ss/sck got %b%b want 01", mcu_ss, mcu_sck); else passed++;
    #3;
    rst = 1'b1;
    #1;
    total++; if ({mcu_ss, mcu_sck, mcu_mosi, byte_ready} !== 4'b1000) $display("FAIL rstmid_async: got %b want 1000", {mcu_ss, mcu_sck, mcu_mosi, byte_ready}); else passed++;
    tick(); tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    total++; if (done_cnt != base_done) $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - base_done); else passed++;
    frame_avail = 1'b1;
    tick();
    frame_avail = 1'b0;
    wait_done(base_done, ok);
    total++; if (!ok) $display("FAIL rstmid_timeout: done got 0 want 1"); else passed++;
    total++; if (last_bytes.size() != 5 || last_bytes[0] !== 8'h00) $display("FAIL rstmid_header: got %h want 00", (last_bytes.size() == 0) ? 8'hxx : last_bytes[0]); else passed++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
